// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the datapath and mem_access_unit.
// master = requester, slave = the access unit.
interface mem_access_unit_if #(
  parameter int ADDRESS_WIDTH = 8
);
  logic                     req_valid_in;
  logic                     req_ready_out;
  logic                     req_write_in;
  logic [1:0]               req_size_in;
  logic                     req_signed_in;
  logic [ADDRESS_WIDTH-1:0] req_address_in;
  logic [31:0]              req_data_in;
  logic                     resp_valid_out;
  logic [31:0]              resp_data_out;
  logic                     resp_error_out;

  modport master (
    output req_valid_in,
    output req_write_in,
    output req_size_in,
    output req_signed_in,
    output req_address_in,
    output req_data_in,
    input  req_ready_out,
    input  resp_valid_out,
    input  resp_data_out,
    input  resp_error_out
  );

  modport slave (
    input  req_valid_in,
    input  req_write_in,
    input  req_size_in,
    input  req_signed_in,
    input  req_address_in,
    input  req_data_in,
    output req_ready_out,
    output resp_valid_out,
    output resp_data_out,
    output resp_error_out
  );
endinterface

// File: rtl/mem_access_unit.sv
// One-at-a-time load/store initiator for the data-side ports of
// tri_port_memory: alignment check, single strobe cycle, load extension.
module mem_access_unit #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  mem_access_unit_if.slave         req_bus,
  output logic [ADDRESS_WIDTH-1:0] mem_address_out,
  output logic [31:0]              mem_write_data_out,
  output logic                     mem_write_out,
  output logic                     mem_read_en_out,
  output logic [1:0]               mem_mode_out,
  input  logic [31:0]              mem_read_data_in
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  typedef struct packed {
    logic                     write;
    logic [1:0]               size;
    logic                     sgn;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [31:0]              data;
  } req_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_ILL  = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  state_t      state_q;
  state_t      state_d;
  req_t        req_q;
  req_t        req_d;
  logic        err_q;
  logic        err_d;
  logic [31:0] rd_q;
  logic [31:0] rd_d;
  logic        ready;
  logic        accept;
  logic        bad;
  logic [31:0] ext;

  // Ready is masked by reset so nothing is accepted while held in reset.
  assign ready  = (state_q == IDLE) && reset_in;
  assign accept = ready && req_bus.req_valid_in;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      req_bus.req_size_in == SZ_ILL:
        bad = 1'b1;
      req_bus.req_size_in == SZ_WORD:
        bad = |req_bus.req_address_in[1:0];
      req_bus.req_size_in == SZ_HALF:
        bad = req_bus.req_address_in[0];
      default:
        bad = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    err_d   = err_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d.write = req_bus.req_write_in;
          req_d.size  = req_bus.req_size_in;
          req_d.sgn   = req_bus.req_signed_in;
          req_d.addr  = req_bus.req_address_in;
          req_d.data  = req_bus.req_data_in;
          err_d       = bad;
          if (bad)
            state_d = RESP;
          else if (req_bus.req_write_in)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        // Memory reads on the falling edge, so data is stable here.
        rd_d    = mem_read_data_in;
        state_d = RESP;
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    ext = rd_q;
    unique case (1'b1)
      req_q.size == SZ_HALF:
        ext = {{16{req_q.sgn & rd_q[15]}}, rd_q[15:0]};
      req_q.size == SZ_BYTE:
        ext = {{24{req_q.sgn & rd_q[7]}}, rd_q[7:0]};
      default:
        ext = rd_q;
    endcase
  end

  assign req_bus.req_ready_out  = ready;
  assign req_bus.resp_valid_out = (state_q == RESP);
  assign req_bus.resp_error_out = (state_q == RESP) && err_q;
  assign req_bus.resp_data_out  =
    ((state_q == RESP) && !err_q && !req_q.write) ? ext : 32'h0;

  assign mem_write_out      = (state_q == WRITE);
  assign mem_read_en_out    = (state_q == READ);
  assign mem_address_out    = req_q.addr;
  assign mem_write_data_out = req_q.data;
  assign mem_mode_out       = req_q.size;

endmodule
